// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared CPU constants (reset/trap vectors, bubble word) and
//                PC arithmetic helpers used by fetch, decode and the
//                exception unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Sequential successor: the supervisor bit is never carried into or out of.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    // J/JAL target keeps the top nibble of the current PC.
    function automatic logic [31:0] jump_addr(input logic [31:0] pc,
                                              input logic [25:0] idx);
        return {pc[31:28], idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Bundle of the fetch stage's control, redirect, ROM and
//                IF/ID signals. master = fetch stage, slave = surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;

    logic        stall;
    logic        flush;
    logic        irq;
    logic        illop;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        irq_ack;
    logic [31:0] epc;

    modport master (
        input  stall, flush, irq, illop,
        input  branch_taken, branch_target, jump, jump_index, jr, jr_target,
        input  rom_data,
        output rom_addr, ifid_inst, ifid_pc_plus4, ifid_valid, irq_ack, epc
    );

    modport slave (
        output stall, flush, irq, illop,
        output branch_taken, branch_target, jump, jump_index, jr, jr_target,
        output rom_data,
        input  rom_addr, ifid_inst, ifid_pc_plus4, ifid_valid, irq_ack, epc
    );

endinterface
`default_nettype wire

// File: rtl/if_stage_pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_mux
//  Description : Combinational next-PC priority selector. Produces next_pc,
//                the IF/ID bubble request, the interrupt-take decision, the
//                stall hold condition and the return address for epc.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_mux
    import if_stage_pkg::*;
(
    input  wire logic [31:0] i_pc,
    input  wire logic        i_stall,
    input  wire logic        i_flush,
    input  wire logic        i_irq,
    input  wire logic        i_illop,
    input  wire logic        i_jr,
    input  wire logic [31:0] i_jr_target,
    input  wire logic        i_jump,
    input  wire logic [25:0] i_jump_index,
    input  wire logic        i_branch_taken,
    input  wire logic [31:0] i_branch_target,
    output logic      [31:0] o_next_pc,
    output logic             o_bubble,
    output logic             o_irq_take,
    output logic             o_hold,
    output logic      [31:0] o_epc_next
);

    logic [31:0] w_jump_pc;
    logic [31:0] w_seq_pc;

    assign w_jump_pc = jump_addr(i_pc, i_jump_index);
    assign w_seq_pc  = pc_inc(i_pc);

    // Priority selection of next PC; interrupts are masked in supervisor mode.
    always_comb begin
        o_irq_take = i_irq & ~i_pc[31] & ~i_stall & ~i_illop;
        o_hold     = i_stall & ~i_illop;
        o_bubble   = i_flush | i_illop | o_irq_take | i_jr | i_jump | i_branch_taken;
        o_next_pc  = w_seq_pc;
        o_epc_next = i_pc;

        if (i_illop)             o_next_pc = XADR_PC;
        else if (o_irq_take)     o_next_pc = ILLOP_PC;
        else if (i_jr)           o_next_pc = i_jr_target;
        else if (i_jump)         o_next_pc = w_jump_pc;
        else if (i_branch_taken) o_next_pc = i_branch_target;

        // A redirect displaced by the interrupt becomes the return address.
        if (i_jr)                o_epc_next = i_jr_target;
        else if (i_jump)         o_epc_next = w_jump_pc;
        else if (i_branch_taken) o_epc_next = i_branch_target;
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage. Holds the PC, addresses the ROM,
//                registers the fetched word into IF/ID and takes timer
//                interrupts only while in user mode (PC[31] = 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    if_stage_if.master  bus
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic        r_irq_ack;
    logic [31:0] r_epc;

    logic [31:0] w_next_pc;
    logic        w_bubble;
    logic        w_irq_take;
    logic        w_hold;
    logic [31:0] w_epc_next;

    pc_next_mux u_pc_next_mux (
        .i_pc            (r_pc),
        .i_stall         (bus.stall),
        .i_flush         (bus.flush),
        .i_irq           (bus.irq),
        .i_illop         (bus.illop),
        .i_jr            (bus.jr),
        .i_jr_target     (bus.jr_target),
        .i_jump          (bus.jump),
        .i_jump_index    (bus.jump_index),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_target (bus.branch_target),
        .o_next_pc       (w_next_pc),
        .o_bubble        (w_bubble),
        .o_irq_take      (w_irq_take),
        .o_hold          (w_hold),
        .o_epc_next      (w_epc_next)
    );

    // PC, IF/ID register, interrupt acknowledge and return address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_ifid_inst     <= NOP;
            r_ifid_pc_plus4 <= RESET_PC;
            r_ifid_valid    <= 1'b0;
            r_irq_ack       <= 1'b0;
            r_epc           <= 32'h0000_0000;
        end else begin
            r_irq_ack <= w_irq_take;
            if (!w_hold) begin
                r_pc <= w_next_pc;
                if (w_bubble) begin
                    r_ifid_inst  <= NOP;
                    r_ifid_valid <= 1'b0;
                end else begin
                    r_ifid_inst     <= bus.rom_data;
                    r_ifid_pc_plus4 <= pc_inc(r_pc);
                    r_ifid_valid    <= 1'b1;
                end
                if (w_irq_take) begin
                    r_epc <= w_epc_next;
                end
            end
        end
    end

    assign bus.rom_addr      = r_pc;
    assign bus.ifid_inst     = r_ifid_inst;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.irq_ack       = r_irq_ack;
    assign bus.epc           = r_epc;

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined CPU: owns the program counter, drives the instruction ROM address, captures the returned word into the IF/ID pipeline register, and selects the next PC among sequential, branch, jump, jump-register, interrupt and exception vectors. The stage sits directly upstream of the instruction ROM and feeds the decode stage. It also enforces the supervisor bit (PC[31]) so that timer interrupts are taken only in user mode.

## Interface
- RESET_PC, 32'h8000_0000, PC after reset; supervisor mode.
- ILLOP_PC, 32'h8000_0004, interrupt vector.
- XADR_PC, 32'h8000_0008, exception (undefined instruction) vector.
- NOP, 32'h0000_0000, word loaded into IF/ID on a bubble.

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  load bubble into IF/ID (redirect from a later stage).
- irq  in  1  level timer interrupt request.
- illop  in  1  undefined instruction detected in decode.
- branch_taken  in  1 / branch_target  in  32  conditional branch redirect.
- jump  in  1 / jump_index  in  26  J/JAL redirect.
- jr  in  1 / jr_target  in  32  JR/JALR redirect.
- rom_addr  out  32  current PC, to ROM (combinational from PC register).
- rom_data  in  32  ROM word for rom_addr, same cycle.
- ifid_inst  out  32  registered instruction.
- ifid_pc_plus4  out  32  registered PC+4 of that instruction.
- ifid_valid  out  1  0 when IF/ID holds a bubble.
- irq_ack  out  1  one-cycle pulse, interrupt accepted.
- epc  out  32  return address captured at interrupt acceptance.

## Operation
- pc_plus4 = {PC[31], PC[30:0] + 4}; PC[31] never altered by the increment (31-bit wrap).
- Jump target = {PC[31:28], jump_index, 2'b00}. Branch and JR targets are used verbatim.
- redirect = illop | irq_take | jr | jump | branch_taken.
- irq_take = irq & ~PC[31] & ~stall & ~illop.
- Next-PC priority, highest first: illop → XADR_PC; irq_take → ILLOP_PC; jr → jr_target; jump → jump target; branch_taken → branch_target; else pc_plus4.
- stall=1 and illop=0: PC, IF/ID, epc hold; redirect inputs ignored (upstream holds them until stall drops).
- illop overrides stall.
- IF/ID load: bubble (NOP, valid=0, pc_plus4 unchanged) when flush | illop | irq_take | jr | jump | branch_taken; else rom_data, pc_plus4, valid=1.
- On irq_take: epc ← lower-priority redirect target if jr/jump/branch_taken is asserted that cycle, else current PC. The fetched word is discarded and re-fetched after return.
- No re-entry: PC[31]=1 inside handlers masks irq; the handler returns via jr to a user-mode address.

## Timing
- Reset values: PC=RESET_PC, rom_addr=RESET_PC, ifid_inst=NOP, ifid_pc_plus4=RESET_PC, ifid_valid=0, irq_ack=0, epc=0.
- After reset release, the first edge latches word 0 into IF/ID. Latency from rom_addr to ifid_inst is 1 cycle.
- A redirect asserted in cycle n gives rom_addr = target in cycle n+1, with exactly one bubble inserted.
- irq_ack is registered: high the cycle after irq_take, for one cycle only. epc is valid in that same cycle.
- An irq arriving during stall is taken on the first non-stalled cycle if still asserted.
- Reset mid-operation discards IF/ID contents and any pending redirect immediately.

## Structure
- Shared CPU package: RESET_PC, ILLOP_PC, XADR_PC and NOP constants, reused by decode and the exception unit.
- One sub-module, pc_next_mux: purely combinational priority selector that outputs next_pc, bubble and irq_take. The PC and IF/ID registers stay in if_stage.

## Test plan
- Reset release with ROM word0 = 0x0800_0016: cycle 1 rom_addr=0x8000_0000; cycle 2 ifid_inst=0x0800_0016, ifid_pc_plus4=0x8000_0004, valid=1.
- jump with jump_index=0x16 at PC=0x8000_0000 → next rom_addr=0x8000_0058; one bubble (valid=0) in IF/ID.
- jr_target=0x0000_000C, then irq=1 in user mode at PC=0x0000_0010 → rom_addr=0x8000_0004 next cycle, epc=0x0000_0010, irq_ack single pulse.
- irq=1 while PC=0x8000_00F8 (supervisor) → ignored; PC keeps incrementing; irq_ack stays 0.
- stall=1 for 3 cycles with branch_taken=1, target 0x40 → PC and IF/ID frozen; branch takes effect on the first unstalled cycle; irq held high during the stall is taken only after it.
- illop with stall=1 and jr=1 simultaneously → rom_addr=0x8000_0008 next cycle, IF/ID bubble, epc unchanged.
